// File: rtl/pci_rr_arbiter_if.sv
// Handshake bundle between the central PCI arbiter and its bus masters.
// The master modport is the arbiter side that drives GNT; the slave modport is the requester side.
interface pci_rr_arbiter_if #(
    parameter int N_MASTERS = 8
);
    logic [N_MASTERS-1:0] REQ;
    logic                 GLOBAL_FRAME;
    logic                 GLOBAL_IRDY;
    logic [N_MASTERS-1:0] GNT;
    logic [2:0]           OWNER;
    logic                 GRANT_VALID;
    logic                 TIMEOUT;

    modport master (
        input  REQ, GLOBAL_FRAME, GLOBAL_IRDY,
        output GNT, OWNER, GRANT_VALID, TIMEOUT
    );

    modport slave (
        output REQ, GLOBAL_FRAME, GLOBAL_IRDY,
        input  GNT, OWNER, GRANT_VALID, TIMEOUT
    );
endinterface

// File: rtl/pci_rr_arbiter.sv
// Round-robin PCI bus arbiter: one active-low GNT at a time, grants move only while the bus is idle.
// Optional bus parking on PARK_MASTER is enabled by defining ARB_PARK_EN.
module pci_rr_arbiter #(
    parameter int N_MASTERS   = 8,
    parameter int GNT_TIMEOUT = 16,
    parameter int PARK_MASTER = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    pci_rr_arbiter_if.master      bus
);

    localparam int CW = (GNT_TIMEOUT > 2) ? $clog2(GNT_TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(GNT_TIMEOUT - 1);
`ifdef ARB_PARK_EN
    localparam logic [2:0] PARK_IDX = 3'(PARK_MASTER);
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_BUSY  = 2'd2
`ifdef ARB_PARK_EN
        , ST_PARK = 2'd3
`endif
    } state_t;

    state_t               state_q, state_d;
    logic [N_MASTERS-1:0] gnt_q, gnt_d;
    logic [2:0]           owner_q, owner_d;
    logic [2:0]           ptr_q, ptr_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 grant_valid_q, grant_valid_d;
    logic                 timeout_q, timeout_d;

    logic                 bus_idle_s;
    logic                 any_req_s;
    logic [2:0]           winner_s;

    function automatic logic [N_MASTERS-1:0] gnt_for(input logic [2:0] idx);
        logic [N_MASTERS-1:0] v;
        v      = '1;
        v[idx] = 1'b0;
        return v;
    endfunction

    assign bus_idle_s = bus.GLOBAL_FRAME & bus.GLOBAL_IRDY;

    // Cyclic search from ptr+1; walking backwards leaves the nearest requester as the winner.
    always_comb begin
        int idx;
        idx       = 0;
        winner_s  = ptr_q;
        any_req_s = 1'b0;
        for (int i = N_MASTERS; i >= 1; i--) begin
            idx       = (int'(ptr_q) + i) % N_MASTERS;
            any_req_s = any_req_s | ~bus.REQ[idx];
            winner_s  = bus.REQ[idx] ? winner_s : 3'(idx);
        end
    end

    // Next-state and next-output logic of the grant FSM.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                gnt_d = '1;
                if (any_req_s && bus_idle_s) begin
                    gnt_d   = gnt_for(winner_s);
                    owner_d = winner_s;
                    cnt_d   = '0;
                    state_d = ST_GRANT;
                end
`ifdef ARB_PARK_EN
                else if (!any_req_s && bus_idle_s) begin
                    gnt_d   = gnt_for(PARK_IDX);
                    owner_d = PARK_IDX;
                    state_d = ST_PARK;
                end
`endif
                else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                cnt_d = cnt_q + 1'b1;
                // FRAME beats withdrawal, withdrawal beats timeout.
                if (!bus.GLOBAL_FRAME) begin
                    ptr_d   = owner_q;
                    state_d = ST_BUSY;
                end else if (bus.REQ[owner_q]) begin
                    gnt_d   = '1;
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    gnt_d     = '1;
                    timeout_d = 1'b1;
                    ptr_d     = owner_q;
                    state_d   = ST_IDLE;
                end else begin
                    state_d = ST_GRANT;
                end
            end
            ST_BUSY: begin
                if (bus_idle_s) begin
                    gnt_d   = '1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_BUSY;
                end
            end
`ifdef ARB_PARK_EN
            ST_PARK: begin
                if (!bus.GLOBAL_FRAME) begin
                    ptr_d   = PARK_IDX;
                    state_d = ST_BUSY;
                end else if (!bus.REQ[PARK_IDX]) begin
                    cnt_d   = '0;
                    state_d = ST_GRANT;
                end else if (any_req_s) begin
                    gnt_d   = '1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_PARK;
                end
            end
`endif
            default: begin
                gnt_d   = '1;
                state_d = ST_IDLE;
            end
        endcase
        grant_valid_d = (gnt_d != '1);
    end

    // State and registered outputs; reset releases the bus immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            gnt_q         <= '1;
            owner_q       <= 3'd0;
            ptr_q         <= 3'(N_MASTERS - 1);
            cnt_q         <= '0;
            grant_valid_q <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            gnt_q         <= gnt_d;
            owner_q       <= owner_d;
            ptr_q         <= ptr_d;
            cnt_q         <= cnt_d;
            grant_valid_q <= grant_valid_d;
            timeout_q     <= timeout_d;
        end
    end

    assign bus.GNT         = gnt_q;
    assign bus.OWNER       = owner_q;
    assign bus.GRANT_VALID = grant_valid_q;
    assign bus.TIMEOUT     = timeout_q;

endmodule

// File: tb/tb_pci_rr_arbiter.sv
// Directed bench for pci_rr_arbiter with hand-computed grant sequences.
// Expectations for the parking scenario follow whether ARB_PARK_EN is defined.
module tb_pci_rr_arbiter;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    pci_rr_arbiter_if #(.N_MASTERS(8)) bus ();

    pci_rr_arbiter #(
        .N_MASTERS  (8),
        .GNT_TIMEOUT(16),
        .PARK_MASTER(0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst              = 1'b1;
        bus.REQ          = 8'hFF;
        bus.GLOBAL_FRAME = 1'b1;
        bus.GLOBAL_IRDY  = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (bus.GNT !== 8'hFF) begin n_fail++; $display("FAIL reset_gnt: got %h want %h", bus.GNT, 8'hFF); end
        n_checks++;
        if (bus.OWNER !== 3'd0) begin n_fail++; $display("FAIL reset_owner: got %0d want 0", bus.OWNER); end
        n_checks++;
        if (bus.GRANT_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.GRANT_VALID); end
        n_checks++;
        if (bus.TIMEOUT !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b want 0", bus.TIMEOUT); end
    endtask

    task automatic test_basic_grant();
        do_reset();
        bus.REQ = 8'hFE;
        tick(1);
        n_checks++;
        if (bus.GNT !== 8'hFE) begin n_fail++; $display("FAIL t1_grant: got %h want %h", bus.GNT, 8'hFE); end
        n_checks++;
        if (bus.OWNER !== 3'd0) begin n_fail++; $display("FAIL t1_owner: got %0d want 0", bus.OWNER); end
        n_checks++;
        if (bus.GRANT_VALID !== 1'b1) begin n_fail++; $display("FAIL t1_valid: got %b want 1", bus.GRANT_VALID); end
        bus.GLOBAL_FRAME = 1'b0;
        tick(1);
        bus.REQ          = 8'hFF;
        bus.GLOBAL_FRAME = 1'b1;
        bus.GLOBAL_IRDY  = 1'b0;
        tick(1);
        n_checks++;
        if (bus.GNT !== 8'hFE) begin n_fail++; $display("FAIL t1_busy_hold: got %h want %h", bus.GNT, 8'hFE); end
        bus.GLOBAL_IRDY = 1'b1;
        tick(1);
        n_checks++;
        if (bus.GNT !== 8'hFF) begin n_fail++; $display("FAIL t1_release: got %h want %h", bus.GNT, 8'hFF); end
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_gnt;
        do_reset();
        bus.REQ = 8'h00;
        tick(1);
        for (int i = 0; i < 9; i++) begin
            exp_gnt        = 8'hFF;
            exp_gnt[i % 8] = 1'b0;
            n_checks++;
            if (bus.GNT !== exp_gnt) begin n_fail++; $display("FAIL rr_gnt[%0d]: got %h want %h", i, bus.GNT, exp_gnt); end
            n_checks++;
            if (bus.OWNER !== 3'(i % 8)) begin n_fail++; $display("FAIL rr_owner[%0d]: got %0d want %0d", i, bus.OWNER, i % 8); end
            bus.GLOBAL_FRAME = 1'b0;
            tick(1);
            bus.GLOBAL_FRAME = 1'b1;
            tick(1);
            n_checks++;
            if (bus.GNT !== 8'hFF) begin n_fail++; $display("FAIL rr_gap[%0d]: got %h want %h", i, bus.GNT, 8'hFF); end
            tick(1);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        bus.REQ = 8'hF7;
        tick(1);
        n_checks++;
        if (bus.GNT !== 8'hF7) begin n_fail++; $display("FAIL to_grant: got %h want %h", bus.GNT, 8'hF7); end
        for (int i = 1; i < 16; i++) begin
            tick(1);
            n_checks++;
            if (bus.GNT !== 8'hF7 || bus.TIMEOUT !== 1'b0) begin
                n_fail++;
                $display("FAIL to_hold[%0d]: got gnt=%h to=%b want gnt=%h to=0", i, bus.GNT, bus.TIMEOUT, 8'hF7);
            end
        end
        tick(1);
        n_checks++;
        if (bus.GNT !== 8'hFF) begin n_fail++; $display("FAIL to_drop: got %h want %h", bus.GNT, 8'hFF); end
        n_checks++;
        if (bus.TIMEOUT !== 1'b1) begin n_fail++; $display("FAIL to_pulse: got %b want 1", bus.TIMEOUT); end
        bus.REQ = 8'hF3;
        tick(1);
        n_checks++;
        if (bus.TIMEOUT !== 1'b0) begin n_fail++; $display("FAIL to_pulse_end: got %b want 0", bus.TIMEOUT); end
        n_checks++;
        if (bus.GNT !== 8'hFB || bus.OWNER !== 3'd2) begin
            n_fail++;
            $display("FAIL to_next: got gnt=%h owner=%0d want gnt=%h owner=2", bus.GNT, bus.OWNER, 8'hFB);
        end
    endtask

    task automatic test_withdraw();
        do_reset();
        bus.GLOBAL_FRAME = 1'b0;
        bus.REQ          = 8'hFE;
        tick(2);
        n_checks++;
        if (bus.GNT !== 8'hFF) begin n_fail++; $display("FAIL wd_busy_bus: got %h want %h", bus.GNT, 8'hFF); end
        bus.GLOBAL_FRAME = 1'b1;
        tick(1);
        n_checks++;
        if (bus.GNT !== 8'hFE) begin n_fail++; $display("FAIL wd_grant: got %h want %h", bus.GNT, 8'hFE); end
        bus.REQ          = 8'hFF;
        bus.GLOBAL_FRAME = 1'b0;
        tick(1);
        n_checks++;
        if (bus.GNT !== 8'hFE) begin n_fail++; $display("FAIL wd_frame_wins: got %h want %h", bus.GNT, 8'hFE); end
        bus.GLOBAL_FRAME = 1'b1;
        tick(1);
        bus.REQ = 8'hFE;
        tick(1);
        n_checks++;
        if (bus.GNT !== 8'hFE) begin n_fail++; $display("FAIL wd_regrant: got %h want %h", bus.GNT, 8'hFE); end
        bus.REQ = 8'hFF;
        tick(1);
        n_checks++;
        if (bus.GNT !== 8'hFF || bus.TIMEOUT !== 1'b0) begin
            n_fail++;
            $display("FAIL wd_drop: got gnt=%h to=%b want gnt=%h to=0", bus.GNT, bus.TIMEOUT, 8'hFF);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.REQ = 8'hDF;
        tick(1);
        bus.GLOBAL_FRAME = 1'b0;
        tick(1);
        n_checks++;
        if (bus.GNT !== 8'hDF) begin n_fail++; $display("FAIL ar_busy: got %h want %h", bus.GNT, 8'hDF); end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (bus.GNT !== 8'hFF) begin n_fail++; $display("FAIL ar_async: got %h want %h", bus.GNT, 8'hFF); end
        bus.GLOBAL_FRAME = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(1);
        n_checks++;
        if (bus.GNT !== 8'hDF || bus.OWNER !== 3'd5) begin
            n_fail++;
            $display("FAIL ar_regrant: got gnt=%h owner=%0d want gnt=%h owner=5", bus.GNT, bus.OWNER, 8'hDF);
        end
    endtask

    task automatic test_park();
        do_reset();
        tick(1);
`ifdef ARB_PARK_EN
        n_checks++;
        if (bus.GNT !== 8'hFE) begin n_fail++; $display("FAIL park_gnt: got %h want %h", bus.GNT, 8'hFE); end
        bus.REQ = 8'hBF;
        tick(1);
        n_checks++;
        if (bus.GNT !== 8'hFF) begin n_fail++; $display("FAIL park_gap: got %h want %h", bus.GNT, 8'hFF); end
        tick(1);
        n_checks++;
        if (bus.GNT !== 8'hBF) begin n_fail++; $display("FAIL park_next: got %h want %h", bus.GNT, 8'hBF); end
`else
        for (int i = 0; i < 3; i++) begin
            tick(1);
            n_checks++;
            if (bus.GNT !== 8'hFF || bus.GRANT_VALID !== 1'b0) begin
                n_fail++;
                $display("FAIL nopark[%0d]: got gnt=%h valid=%b want gnt=%h valid=0", i, bus.GNT, bus.GRANT_VALID, 8'hFF);
            end
        end
`endif
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_basic_grant();
        test_round_robin();
        test_timeout();
        test_withdraw();
        test_async_reset();
        test_park();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
